rom_streamer: RTL and testbench

Sequencer that sits directly upstream of the single-port synchronous-read ROM and consumes its read data. It accepts a burst command (base address, length), drives the ROM address port one word per cycle, and returns the words on a valid/ready output stream, honouring backpressure without losing or duplicating words. The ROM has a fixed one-cycle read latency: an address presented in cycle N yields data in cycle N+1.

---
 rtl/rom_streamer.sv | 196 +++++++++++++++++++
 tb/tb_rom_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_streamer.sv
// rom_streamer: burst sequencer in front of a one-cycle-latency synchronous ROM.
// It accepts (base address, length) commands, issues one ROM address per cycle
// and returns the words on a valid/ready stream through a 2-entry output FIFO.
// Issue is credit-limited so that in-flight words plus buffered words never
// exceed the FIFO depth, which keeps backpressure from losing any word.
// Optional feature macro: ROM_STREAMER_CHECKSUM_EN. When it is defined, a
// running modulo-2^DATA_WIDTH sum of popped words is kept on checksum.
module rom_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] next_addr_reg, next_addr_next;
  logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
  logic [ADDR_WIDTH-1:0] rom_addr_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic                  cmd_ready_reg;
  logic                  busy_reg;
  logic                  done_reg, done_next;

  // Output FIFO bookkeeping
  logic [1:0]            count_reg, count_next;
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [DATA_WIDTH-1:0] entry_data [2];
  logic                  entry_last [2];

  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [2:0]            credit_used;

  assign accept      = cmd_valid && cmd_ready_reg;
  assign push        = inflight_reg;
  assign out_valid   = (count_reg != 2'd0);
  assign pop         = out_valid && out_ready;
  // Slots already claimed in the FIFO once this cycle's pop is accounted for.
  assign credit_used = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign count_next  = count_reg + {1'b0, push} - {1'b0, pop};

  // The address port shows the new address in the issue cycle and holds it after.
  assign rom_addr  = issue ? next_addr_reg : rom_addr_reg;
  assign out_data  = entry_data[rd_ptr_reg];
  assign out_last  = entry_last[rd_ptr_reg];
  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  // Next-state, issue decision and done pulse generation.
  always_comb begin
    state_next     = state_reg;
    next_addr_next = next_addr_reg;
    remaining_next = remaining_reg;
    issue          = 1'b0;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          next_addr_next = cmd_addr;
          remaining_next = cmd_len;
          if (cmd_len == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if ((remaining_reg != '0) && (credit_used < 3'd2)) begin
          issue          = 1'b1;
          next_addr_next = next_addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == LEN_WIDTH'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave as soon as the final word is popped so the next command can be
        // accepted in the done cycle.
        if (count_next == 2'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      next_addr_reg     <= '0;
      remaining_reg     <= '0;
      rom_addr_reg      <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      cmd_ready_reg     <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      next_addr_reg     <= next_addr_next;
      remaining_reg     <= remaining_next;
      if (issue) begin
        rom_addr_reg <= next_addr_reg;
      end
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (remaining_reg == LEN_WIDTH'(1));
      cmd_ready_reg     <= (state_next == IDLE);
      busy_reg          <= (state_next != IDLE);
      done_reg          <= done_next;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  // One storage slot per FIFO entry, written with the ROM word one cycle after issue.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  last_reg;

      // Capture the in-flight ROM word into this slot when it is the write target.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
          last_reg <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= rom_data;
          last_reg <= inflight_last_reg;
        end
      end

      assign entry_data[gi] = data_reg;
      assign entry_last[gi] = last_reg;
    end
  endgenerate

`ifdef ROM_STREAMER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_reg;

  // Sum of popped words, restarted by each accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= '0;
    end else if (pop) begin
      checksum_reg <= checksum_reg + out_data;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: self-checking bench for rom_streamer with a behavioural ROM.
// Expected words come from a queue built from the ROM contents for each burst;
// directed bursts carry their expected timing in a table, random bursts use
// random addresses, lengths, ROM contents and backpressure.
module tb_rom_streamer;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int LW   = 9;
  localparam int SKIP = -2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  logic [DW-1:0] rom_mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  rom_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            bp;         // 0: always ready, 1: 1,0,0 pattern, 2: random
    int            exp_done;   // cycle offset of done after acceptance, SKIP = unchecked
    int            exp_first;  // offset of first pop, -1 = none expected
    int            exp_last;   // offset of final pop
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one command and follow it to completion (or until stop_pops words popped).
  task automatic run_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input int bp,
                         input int exp_done, input int exp_first, input int exp_last,
                         input int stop_pops);
    logic [DW-1:0] qd[$];
    logic          ql[$];
    logic [DW-1:0] sum;
    logic [AW-1:0] ad;
    logic [AW-1:0] idx;
    int            waited;
    int            first;
    int            lastpop;
    int            done_at;
    int            pops;
    int            budget;
    sum     = '0;
    waited  = 0;
    first   = -1;
    lastpop = -1;
    done_at = -1;
    pops    = 0;
    budget  = int'(l) * 8 + 60;
    for (int i = 0; i < int'(l); i++) begin
      ad = a + AW'(i);
      qd.push_back(rom_mem[ad]);
      ql.push_back(i == int'(l) - 1);
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    while (cmd_ready !== 1'b1) begin
      if (waited >= 20) begin
        check("cmd_ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (bp == 0)      out_ready = 1'b1;
      else if (bp == 1) out_ready = ((k - 1) % 3 == 0);
      else              out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (l == '0 && k == 1) check("zero_len_cmd_ready", 32'(cmd_ready), 32'd1);
      if (l != '0) begin
        idx = rom_addr - a;
        check("lookahead_le2", 32'((int'(idx) - pops) > 2), 32'd0);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (first < 0) first = k;
        lastpop = k;
        pops++;
        if (qd.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          check("data", 32'(out_data), 32'(qd[0]));
          check("last", 32'(out_last), 32'(ql[0]));
          sum = sum + qd[0];
          void'(qd.pop_front());
          void'(ql.pop_front());
        end
      end
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      check("busy_during", 32'(busy), 32'd1);
      if (stop_pops >= 0 && pops == stop_pops) return;
      @(posedge clk);
      #1;
    end
    if (done_at < 0) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    check("busy_at_done", 32'(busy), 32'd0);
    check("words_left", 32'(qd.size()), 32'd0);
    if (exp_done != SKIP)  check("done_offset", 32'(done_at), 32'(exp_done));
    if (exp_first != SKIP) check("first_pop_offset", 32'(first), 32'(exp_first));
    if (exp_last != SKIP)  check("last_pop_offset", 32'(lastpop), 32'(exp_last));
`ifdef ROM_STREAMER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(sum));
`else
    check("checksum", 32'(checksum), 32'd0);
`endif
    $display("burst addr=%02h len=%0d bp=%0d words=%0d done@C+%0d sum=%02h",
             a, l, bp, pops, done_at, sum);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    int rbp;

    for (int i = 0; i < 256; i++) rom_mem[i] = DW'(i);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;

    vecs[0] = '{8'h10, 9'd4,   0, 7,    3,    6};
    vecs[1] = '{8'hFE, 9'd4,   0, 7,    3,    6};
    vecs[2] = '{8'h33, 9'd6,   1, SKIP, SKIP, SKIP};
    vecs[3] = '{8'h00, 9'd0,   0, 1,    -1,   -1};
    vecs[4] = '{8'h00, 9'd256, 0, 259,  3,    258};
    vecs[5] = '{8'h80, 9'd1,   0, 4,    3,    3};
    vecs[6] = '{8'hA0, 9'd0,   1, 1,    -1,   -1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed bursts from the table (identity ROM).
    for (int v = 0; v < 7; v++) begin
      run_cmd(vecs[v].addr, vecs[v].len, vecs[v].bp, vecs[v].exp_done,
              vecs[v].exp_first, vecs[v].exp_last, -1);
    end

    // Reset in the middle of a burst after three words have been popped.
    run_cmd(8'h20, 9'd10, 0, SKIP, SKIP, SKIP, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_quiet", 32'(done | out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    run_cmd(8'h40, 9'd1, 0, SKIP, 3, 3, -1);
    $display("mid-burst reset recovered");

    // Random ROM contents, random bursts and backpressure.
    for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);
    for (int r = 0; r < 25; r++) begin
      ra  = AW'($urandom);
      rl  = (r == 24) ? 9'd40 : LW'($urandom_range(0, 12));
      rbp = $urandom_range(0, 2);
      run_cmd(ra, rl, rbp,
              (rbp == 0) ? ((rl == '0) ? 1 : int'(rl) + 3) : SKIP,
              (rl == '0) ? -1 : ((rbp == 0) ? 3 : SKIP),
              (rl == '0) ? -1 : ((rbp == 0) ? int'(rl) + 2 : SKIP),
              -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
